// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, FSM state and address type for the multi-port register file.
package regfile_pkg;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  typedef enum logic {CLEAR, RUN} rf_state_t;
  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits; reservation beats a same-cycle write, x0 never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_WRITE  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_WRITE-1:0]                 we,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] waddr,
  input  logic                                 rsv_en,
  input  logic [ADDR_WIDTH-1:0]                rsv_addr,
  output logic [2**ADDR_WIDTH-1:0]             busy
);
  logic [2**ADDR_WIDTH-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WRITE; p++)
      if (we[p]) busy_d[waddr[p]] = 1'b0;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) busy_q <= rst ? '0 : busy_d;
  assign busy = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0, post-reset clear sweep and hazard scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic                                 ready,
  input  logic [NUM_WRITE-1:0]                 we,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wdata,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  raddr,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rdata,
  output logic [NUM_READ-1:0]                  rbusy,
  input  logic                                 rsv_en,
  input  logic [ADDR_WIDTH-1:0]                rsv_addr
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  rf_state_t             state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DEPTH-1:0]      busy;
  logic                  run;
  assign run   = state_q == RUN;
  assign ready = run;
  // Later write ports are assigned last, so the highest index wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else if (!run) begin
      mem_q[idx_q] <= '0;
      idx_q        <= idx_q + 1'b1;
      if (&idx_q) state_q <= RUN;
    end else begin
      for (int p = 0; p < NUM_WRITE; p++)
        if (we[p] && waddr[p] != '0) mem_q[waddr[p]] <= wdata[p];
    end
  end
  regfile_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_WRITE(NUM_WRITE)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (we & {NUM_WRITE{run}}),
    .waddr    (waddr),
    .rsv_en   (rsv_en & run),
    .rsv_addr (rsv_addr),
    .busy     (busy)
  );
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rdata[i] = (run && raddr[i] != '0) ? mem_q[raddr[i]] : '0;
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NUM_WRITE; p++)
        if (run && we[p] && waddr[p] != '0 && waddr[p] == raddr[i]) rdata[i] = wdata[p];
`endif
      rbusy[i] = run & busy[raddr[i]];
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard-driven bench for regfile_mp with two write ports.
module tb_regfile_mp;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ready;
  logic [1:0]       we = '0;
  logic [1:0][4:0]  waddr = '0;
  logic [1:0][31:0] wdata = '0;
  logic [1:0][4:0]  raddr = '0;
  logic [1:0][31:0] rdata;
  logic [1:0]       rbusy;
  logic             rsv_en = 1'b0;
  logic [4:0]       rsv_addr = '0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {string tag; int sel; logic [31:0] val;} exp_t;
  exp_t sb_q[$];
  regfile_mp #(.NUM_WRITE(2)) dut (
    .clk(clk), .rst(rst), .ready(ready), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );
  always #5 clk = ~clk;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return 32'(ready);
      1: return rdata[0];
      2: return rdata[1];
      3: return 32'(rbusy[0]);
      default: return 32'(rbusy[1]);
    endcase
  endfunction
  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    we = '0;
    rsv_en = 1'b0;
  endtask
  task automatic wait_ready(output int k);
    k = 0;
    while (!ready && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    raddr[0] = 5'd7;
    raddr[1] = 5'd9;
    repeat (2) begin @(posedge clk); #1; end
    push("rst_ready", 0, 0);
    push("rst_rdata0", 1, 0);
    push("rst_rdata1", 2, 0);
    push("rst_rbusy0", 3, 0);
    push("rst_rbusy1", 4, 0);
    step();
    // Sweep with a write to x5 that must be ignored.
    rst = 1'b0;
    we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd5;
    wait_ready(k);
    check("sweep_len", k, 32);
    idle();
    raddr[0] = 5'd5; raddr[1] = 5'd5;
    push("x5_clear", 1, 0);
    push("x5_busy", 3, 0);
    push("ready_run", 0, 1);
    step();
    // x0 is hard-wired
    we = 2'b01; waddr[0] = 5'd0; wdata[0] = 32'hDEAD_BEEF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    raddr[0] = 5'd0; raddr[1] = 5'd0;
    push("x0_same", 1, 0);
    step();
    idle();
    push("x0_rd0", 1, 0);
    push("x0_rd1", 2, 0);
    push("x0_busy0", 3, 0);
    push("x0_busy1", 4, 0);
    step();
    // write then read
    we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'h1234_5678;
    step();
    idle();
    raddr[0] = 5'd7; raddr[1] = 5'd7;
    push("x7_rd0", 1, 32'h1234_5678);
    push("x7_rd1", 2, 32'h1234_5678);
    step();
    // bypass vs old value
    we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h1111_1111;
    step();
    wdata[0] = 32'hA5A5_A5A5;
    raddr[0] = 5'd3;
    push("x3_same", 1, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
    push("x3_same_busy", 3, 0);
    step();
    idle();
    push("x3_next", 1, 32'hA5A5_A5A5);
    step();
    // write collision, highest port wins
    we = 2'b11; waddr[0] = 5'd4; waddr[1] = 5'd4; wdata[0] = 32'd1; wdata[1] = 32'd2;
    raddr[0] = 5'd4;
    push("x4_same", 1, BYP ? 32'd2 : 32'd0);
    step();
    idle();
    push("x4_coll", 1, 32'd2);
    step();
    // scoreboard
    rsv_en = 1'b1; rsv_addr = 5'd9;
    raddr[0] = 5'd9; raddr[1] = 5'd9;
    step();
    idle();
    push("x9_rsv0", 3, 1);
    push("x9_rsv1", 4, 1);
    step();
    we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h99;
    push("x9_busy_wr", 4, 1);
    step();
    idle();
    push("x9_clr", 4, 0);
    push("x9_data", 2, 32'h99);
    step();
    we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h77;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    step();
    idle();
    push("x9_both_busy", 4, 1);
    push("x9_both_data", 2, 32'h77);
    step();
    rsv_en = 1'b1; rsv_addr = 5'd10;
    step();
    idle();
    raddr[1] = 5'd10;
    push("x10_rsv", 4, 1);
    step();
    we = 2'b10; waddr[1] = 5'd10; wdata[1] = 32'h10;
    step();
    idle();
    push("x10_clr_p1", 4, 0);
    push("x10_data", 2, 32'h10);
    step();
    // mid-run then mid-sweep reset
    we = 2'b01; waddr[0] = 5'd20; wdata[0] = 32'hCAFE_0020;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    step();
    idle();
    raddr[0] = 5'd20; raddr[1] = 5'd12;
    push("x20_pre", 1, 32'hCAFE_0020);
    push("x12_pre", 4, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    push("sweep_rdata", 1, 0);
    push("sweep_rbusy", 4, 0);
    push("sweep_ready", 0, 0);
    step();
    rst = 1'b0;
    wait_ready(k);
    check("resweep_len", k, 32);
    push("x20_cleared", 1, 0);
    push("x12_cleared", 4, 0);
    push("ready_again", 0, 1);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RV32I core, successor to the single-write/dual-read register file. Adds configurable read/write port counts, hard-wired x0, a sequential clear sweep after reset, and a per-register pending-write scoreboard used by decode for hazard detection. Sits between decode (reads, reservations) and writeback (writes).

## Interface
- `DATA_WIDTH`, default 32: register width.
- `ADDR_WIDTH`, default 5: register index width; `DEPTH = 2**ADDR_WIDTH`.
- `NUM_READ`, default 2: read ports.
- `NUM_WRITE`, default 1: write ports.

Reset is synchronous and active-high, with one clock:
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ready`  out  1  high once the clear sweep completes.
- `we`  in  NUM_WRITE  per-port write enable.
- `waddr`  in  NUM_WRITE x ADDR_WIDTH  write index.
- `wdata`  in  NUM_WRITE x DATA_WIDTH  write data.
- `raddr`  in  NUM_READ x ADDR_WIDTH  read index.
- `rdata`  out  NUM_READ x DATA_WIDTH  read data, combinational.
- `rbusy`  out  NUM_READ  read register has a pending write.
- `rsv_en`  in  1  reserve `rsv_addr` (instruction issued with that rd).
- `rsv_addr`  in  ADDR_WIDTH  register to mark busy.

## Operation
- FSM states: CLEAR, RUN.
- `rst` high at an edge: state becomes CLEAR, sweep index 0, all busy bits 0.
- In CLEAR:
  - Each cycle writes 0 to entry[index], then increments the index.
  - After entry DEPTH-1 is cleared, the FSM moves to RUN.
  - `we` and `rsv_en` are ignored; `ready`=0; `rdata`=0; `rbusy`=0.
- In RUN, `ready`=1.
- x0: writes to address 0 are dropped; reads of address 0 return 0; reservations of address 0 are dropped; `rbusy` for address 0 is always 0.
- Write ports: when several enabled ports target the same address in one cycle, the highest port index wins.
- Scoreboard:
  - `rsv_en` sets busy[rsv_addr] at the edge.
  - Any enabled write clears busy[waddr] at the edge.
  - Reserve and write to the same address in the same cycle: busy ends set (reservation wins); data is still written.
- `rbusy[i]` = busy[raddr[i]], registered state only; no bypass applies.

## Timing
- Reads are zero-latency combinational from the array.
- Writes are visible through `rdata` the cycle after the edge, unless bypass is enabled (see Configuration).
- Clear sweep takes exactly DEPTH cycles after the first cycle with `rst` low. With defaults, `ready` rises at the 32nd edge after `rst` deasserts.
- `rst` asserted mid-sweep or in RUN: the sweep restarts from index 0 and busy bits clear; no partial state survives.
- Reset values: `ready`=0, `rdata`=0, `rbusy`=0, state CLEAR, index 0.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined:
  - In RUN, a read whose address matches an enabled write port (non-zero address) in the same cycle returns that port's `wdata`.
  - If several ports match, the highest-index port's data is returned.
  - `rbusy` is unaffected.
- Undefined: a read returns the array contents, i.e. the old value, during a same-cycle write.

## Structure
- Shared package `regfile_pkg`:
  - Default width constants.
  - `rf_state_t` enum (CLEAR, RUN).
  - The `rf_addr_t` typedef.
- Sub-module `regfile_scoreboard`:
  - Holds the busy vector, with set/clear priority logic and x0 masking.
  - Inputs: `clk`, `rst`, `we`, `waddr`, `rsv_en`, `rsv_addr`.
  - Outputs: busy vector.
- The array, sweep FSM and bypass stay in `regfile_mp`.

## Test plan
- Reset sweep: deassert `rst`, with `we[0]`=1 to x5 during the sweep -> `ready` rises after exactly 32 cycles; x5 reads 0.
- x0: write 0xDEADBEEF to x0, `rsv_en` on x0 -> `rdata` 0 and `rbusy` 0 on both ports.
- Write/read: write 0x12345678 to x7, read x7 on both ports next cycle -> 0x12345678.
- Bypass: same-cycle write 0xA5A5A5A5 to x3 and read x3 -> 0xA5A5A5A5 with `REGFILE_BYPASS_EN`; previous value without it.
- Scoreboard:
  - Reserve x9 -> `rbusy` 1 next cycle.
  - Write x9 -> `rbusy` 0 next cycle.
  - Reserve and write x9 in the same cycle -> `rbusy` stays 1.
- Mid-operation reset and write collision:
  - With NUM_WRITE=2, ports 0 and 1 write x4 with 1 and 2 -> x4 reads 2.
  - Assert `rst` at sweep index 10 -> sweep restarts; `ready` low for a further 32 cycles.
